x_corr_feeder: RTL and testbench

- Transmit-side companion to the cross-correlator: buffers one reference block (x) and one received block (y), then streams the (x, y) complex sample pairs for every circular lag.
- Each lag is a run of `length` pairs on the stream the correlator consumes, so the downstream dot-product/argmax chain produces one result per lag.
- Sits between the sample capture path and the correlator. One load of `length` pairs per correlation run.

---
 rtl/x_corr_feeder.sv | 156 +++++++++++++++
 tb/tb_x_corr_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_corr_feeder.sv
// Buffers one x block and one y block, then streams (x[n], y[(n+k) mod length]) for every lag k.
// First pair is valid the cycle after start is sampled in FULL; the stream stalls losslessly on !m_axis_tready.
module x_corr_feeder #(
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int length              = 5,
  parameter int length_counter_bits = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [xi_bits-1:0]             in_xi,
  input  logic [xq_bits-1:0]             in_xq,
  input  logic [yi_bits-1:0]             in_yi,
  input  logic [yq_bits-1:0]             in_yq,
  input  logic                           m_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           start,
  output logic [xi_bits-1:0]             xi,
  output logic [xq_bits-1:0]             xq,
  output logic [yi_bits-1:0]             yi,
  output logic [yq_bits-1:0]             yq,
  output logic [length_counter_bits-1:0] lag,
  output logic                           tlast,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           done
);

  localparam int cw = length_counter_bits;
  localparam logic [cw-1:0] last_idx = cw'(length - 1);
  localparam logic [cw:0]   len_ext  = (cw + 1)'(length);

  typedef enum logic [1:0] {LOAD, FULL, STREAM} state_t;

  state_t        state;
  logic [cw-1:0] wr;
  logic [cw-1:0] n;
  logic [cw-1:0] k;
  logic          pending;

  logic [xi_bits-1:0] x_mem_i [length];
  logic [xq_bits-1:0] x_mem_q [length];
  logic [yi_bits-1:0] y_mem_i [length];
  logic [yq_bits-1:0] y_mem_q [length];

  logic          load_en;
  logic          issue;
  logic          end_run;
  logic          wr_fire;
  logic [cw:0]   sum;
  logic [cw-1:0] y_idx;

  // Circular index: n and k are both < length, so one conditional subtract suffices.
  always_comb begin
    sum   = {1'b0, n} + {1'b0, k};
    y_idx = cw'(sum);
    if (sum >= len_ext) begin
      y_idx = cw'(sum - len_ext);
    end
  end

  assign load_en = !s_axis_tvalid || m_axis_tready;
  assign issue   = load_en && (((state == FULL) && start) || ((state == STREAM) && pending));
  // Once nothing is pending, the held pair is the final one of the run.
  assign end_run = (state == STREAM) && !pending && s_axis_tvalid && m_axis_tready;
  assign wr_fire = (state == LOAD) && m_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      x_mem_i[wr] <= in_xi;
      x_mem_q[wr] <= in_xq;
      y_mem_i[wr] <= in_yi;
      y_mem_q[wr] <= in_yq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      wr            <= '0;
      n             <= '0;
      k             <= '0;
      pending       <= 1'b0;
      s_axis_tready <= 1'b1;
      s_axis_tvalid <= 1'b0;
      tlast         <= 1'b0;
      done          <= 1'b0;
      xi            <= '0;
      xq            <= '0;
      yi            <= '0;
      yq            <= '0;
      lag           <= '0;
    end else begin
      done <= 1'b0;

      if (load_en) begin
        s_axis_tvalid <= issue;
        if (issue) begin
          xi    <= x_mem_i[n];
          xq    <= x_mem_q[n];
          yi    <= y_mem_i[y_idx];
          yq    <= y_mem_q[y_idx];
          lag   <= k;
          tlast <= (n == last_idx);
        end
      end

      case (state)
        LOAD: begin
          if (wr_fire) begin
            if (wr == last_idx) begin
              state         <= FULL;
              s_axis_tready <= 1'b0;
              wr            <= '0;
            end else begin
              wr <= wr + 1'b1;
            end
          end
        end
        FULL: begin
          if (start) begin
            state   <= STREAM;
            pending <= 1'b1;
          end
        end
        STREAM: begin
          if (end_run) begin
            state         <= LOAD;
            s_axis_tready <= 1'b1;
            done          <= 1'b1;
            wr            <= '0;
          end
        end
        default: state <= LOAD;
      endcase

      // Advance after the case so the final wrap can clear pending set on entry.
      if (issue) begin
        if (n == last_idx) begin
          n <= '0;
          if (k == last_idx) begin
            k       <= '0;
            pending <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end else begin
          n <= n + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_x_corr_feeder.sv
// Directed scenario sequence with random sample data, checked against a lag-table model.
module tb_x_corr_feeder;

  localparam int L  = 5;
  localparam int CW = 3;
  localparam int W  = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_xi, in_xq, in_yi, in_yq;
  logic          m_axis_tvalid;
  logic          s_axis_tready;
  logic          start;
  logic [W-1:0]  xi, xq, yi, yq;
  logic [CW-1:0] lag;
  logic          tlast;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mxi [L];
  logic [W-1:0] mxq [L];
  logic [W-1:0] myi [L];
  logic [W-1:0] myq [L];
  logic [63:0]  exp_q [$];

  always #5 clk = ~clk;

  x_corr_feeder #(
    .xi_bits(W), .xq_bits(W), .yi_bits(W), .yq_bits(W),
    .length(L), .length_counter_bits(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_xi(in_xi), .in_xq(in_xq), .in_yi(in_yi), .in_yq(in_yq),
    .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
    .start(start),
    .xi(xi), .xq(xq), .yi(yi), .yq(yq), .lag(lag), .tlast(tlast),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
    .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d,
                                            input logic [CW-1:0] l, input logic t);
    return {12'b0, a, b, c, d, l, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block contents: fixed ramp for the reference scenario, otherwise random.
  task automatic set_block(input bit fixed);
    for (int i = 0; i < L; i++) begin
      if (fixed) begin
        mxi[i] = W'(i + 1);
        mxq[i] = '0;
        myi[i] = W'(10 * (i + 1));
        myq[i] = '0;
      end else begin
        mxi[i] = W'($urandom);
        mxq[i] = W'($urandom);
        myi[i] = W'($urandom);
        myq[i] = W'($urandom);
      end
    end
  endtask

  // Each lag k pairs x[n] with y rotated left by k.
  task automatic build_expected();
    exp_q.delete();
    for (int k = 0; k < L; k++) begin
      for (int n = 0; n < L; n++) begin
        int j;
        j = (n + k) % L;
        exp_q.push_back(pack_beat(mxi[n], mxq[n], myi[j], myq[j], CW'(k), n == L - 1));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    start = 1'b0;
    in_xi = '0; in_xq = '0; in_yi = '0; in_yq = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_tready", s_axis_tready, 1);
    check("rst_tvalid", s_axis_tvalid, 0);
    check("rst_done", done, 0);
    check("rst_tlast", tlast, 0);
    check("rst_data", {xi, xq, yi, yq, lag}, 0);
  endtask

  task automatic load(input int nbeats, input int start_after);
    for (int i = 0; i < nbeats; i++) begin
      if (i < L) begin
        in_xi = mxi[i]; in_xq = mxq[i]; in_yi = myi[i]; in_yq = myq[i];
      end else begin
        in_xi = W'($urandom); in_xq = W'($urandom); in_yi = W'($urandom); in_yq = W'($urandom);
      end
      m_axis_tvalid = 1'b1;
      start = (i == start_after);
      check($sformatf("load_rdy%0d", i), s_axis_tready, (i < L));
      tick();
    end
    m_axis_tvalid = 1'b0;
    start = 1'b0;
    check("rdy_after_load", s_axis_tready, 0);
    tick();
    check("idle_before_start", s_axis_tvalid, 0);
    check("rdy_in_full", s_axis_tready, 0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic stream(input int mode, input int abort_at);
    int          got;
    int          cyc;
    logic        stalled;
    logic [63:0] held;
    logic [63:0] cur;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    start = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    check("first_pair_latency", s_axis_tvalid, 1);
    while (got < L * L && cyc < 2000) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      cur = pack_beat(xi, xq, yi, yq, lag, tlast);
      if (stalled) begin
        check("hold_stable", cur, held);
        check("hold_valid", s_axis_tvalid, 1);
      end
      if (mode == 0) check("no_bubble", s_axis_tvalid, 1);
      check("done_early", done, 0);
      if (s_axis_tvalid && m_axis_tready) begin
        got++;
        if (got == abort_at) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check("abort_tvalid", s_axis_tvalid, 0);
          check("abort_done", done, 0);
          check("abort_tready", s_axis_tready, 1);
          m_axis_tready = 1'b0;
          return;
        end
        check($sformatf("beat%0d", got), cur, exp_q.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = s_axis_tvalid;
        held = cur;
      end
      tick();
      cyc++;
    end
    check("beat_count", got, L * L);
    check("end_tvalid", s_axis_tvalid, 0);
    check("end_done", done, 1);
    check("end_tready", s_axis_tready, 1);
    m_axis_tready = 1'b0;
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    do_reset();

    set_block(1'b1);
    load(L, -1);
    build_expected();
    stream(0, 0);

    load(L, -1);
    build_expected();
    stream(1, 0);

    set_block(1'b0);
    load(7, 3);
    build_expected();
    stream(2, 0);

    set_block(1'b0);
    load(L, -1);
    build_expected();
    stream(0, 12);

    set_block(1'b0);
    load(L, -1);
    build_expected();
    stream(0, 0);

    set_block(1'b0);
    load(L, -1);
    build_expected();
    stream(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
